// File: rtl/laser_aom_arbiter.sv
// laser_aom_arbiter: arbitrates two AOM voltage sources onto a valid/ready DAC port, with settle gap and overload fault shutdown.
module laser_aom_arbiter #(
  parameter real TCQ        = 0.1,
  parameter int  SETTLE_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  src_mask_i,
  input  logic        req0_en_i,
  input  logic        req1_en_i,
  input  logic [11:0] req0_vol_i,
  input  logic [11:0] req1_vol_i,
  input  logic [11:0] aom_overload_vol_thre_i,
  input  logic [31:0] aom_overload_timeout_i,
  input  logic        fault_clr_i,
  output logic        dac_valid_o,
  output logic [11:0] dac_data_o,
  input  logic        dac_ready_i,
  output logic [11:0] aom_voltage_o,
  output logic        overload_fault_o,
  output logic        busy_o,
  output logic [15:0] ovr_cnt_o
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_FISSUE, S_FHOLD} state_t;
  state_t      r_state, w_nxt;
  logic [1:0]  r_pend;
  logic [11:0] r_pval0, r_pval1, r_dac_data, r_aom;
  logic        r_fault;
  logic [7:0]  r_settle;
  logic [31:0] r_ovl;
  logic [15:0] r_ovr;
  logic        w_hs, w_above, w_fault_set, w_flt, w_g0, w_g1;
  logic [1:0]  w_pm, w_take, w_acc, w_ovr_inc, w_pend_nxt;
  logic [16:0] w_ovr_sum;
  logic [11:0] w_data_nxt;
  assign dac_valid_o      = (r_state == S_ISSUE) || (r_state == S_FISSUE);
  assign dac_data_o       = r_dac_data;
  assign aom_voltage_o    = r_aom;
  assign overload_fault_o = r_fault;
  assign busy_o           = r_state != S_IDLE;
  assign ovr_cnt_o        = r_ovr;
  assign w_hs        = dac_valid_o & dac_ready_i;
  assign w_above     = r_aom > aom_overload_vol_thre_i;
  // >= rather than == so a timeout lowered below an already-running count still trips
  assign w_fault_set = !r_fault && (aom_overload_timeout_i != 32'd0) && w_above &&
                       (r_ovl >= aom_overload_timeout_i - 32'd1);
  assign w_flt       = r_fault | w_fault_set;
  assign w_pm        = r_pend & src_mask_i;
  assign w_g1        = (r_state == S_IDLE) && !w_flt && w_pm[1];
  assign w_g0        = (r_state == S_IDLE) && !w_flt && w_pm[0] && !w_pm[1];
  assign w_take      = {w_g1, w_g0};
  assign w_acc       = {req1_en_i, req0_en_i} & src_mask_i & {2{!w_flt}};
  assign w_ovr_inc   = w_acc & r_pend & ~w_take;
  assign w_ovr_sum   = {1'b0, r_ovr} + 17'(w_ovr_inc[0]) + 17'(w_ovr_inc[1]);
  assign w_pend_nxt  = w_flt ? 2'b00 : (w_acc | (r_pend & ~w_take)) & src_mask_i;
  assign w_data_nxt  = (w_nxt == S_FISSUE && r_state != S_FISSUE) ? 12'h000 :
                       w_g1 ? r_pval1 : w_g0 ? r_pval0 : r_dac_data;
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   w_nxt = w_flt ? S_FISSUE : (|w_pm) ? S_ISSUE : S_IDLE;
      S_ISSUE:  w_nxt = !w_hs ? S_ISSUE : w_flt ? S_FISSUE : (SETTLE_CYC == 0) ? S_IDLE : S_SETTLE;
      S_SETTLE: w_nxt = w_flt ? S_FISSUE : (r_settle == 8'd0) ? S_IDLE : S_SETTLE;
      S_FISSUE: w_nxt = w_hs ? S_FHOLD : S_FISSUE;
      S_FHOLD:  w_nxt = fault_clr_i ? S_IDLE : S_FHOLD;
      default:  w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_pend     <= 2'b00;
      r_pval0    <= 12'h000;
      r_pval1    <= 12'h000;
      r_dac_data <= 12'h000;
      r_aom      <= 12'h000;
      r_fault    <= 1'b0;
      r_settle   <= 8'd0;
      r_ovl      <= 32'd0;
      r_ovr      <= 16'd0;
    end else begin
      r_state    <= w_nxt;
      r_pend     <= w_pend_nxt;
      r_pval0    <= w_acc[0] ? req0_vol_i : r_pval0;
      r_pval1    <= w_acc[1] ? req1_vol_i : r_pval1;
      r_dac_data <= w_data_nxt;
      r_aom      <= w_hs ? r_dac_data : r_aom;
      r_fault    <= w_fault_set ? 1'b1 : (r_state == S_FHOLD && fault_clr_i) ? 1'b0 : r_fault;
      r_settle   <= (r_state == S_ISSUE) ? 8'(SETTLE_CYC - 1) :
                    (r_state == S_SETTLE) ? r_settle - 8'd1 : r_settle;
      r_ovl      <= (r_state == S_FHOLD || !w_above) ? 32'd0 : r_ovl + {31'd0, ~&r_ovl};
      r_ovr      <= w_ovr_sum[16] ? 16'hFFFF : w_ovr_sum[15:0];
    end
  end
endmodule

// File: tb/tb_laser_aom_arbiter.sv
// tb_laser_aom_arbiter: directed checks of arbitration, settle timing, overwrite counting, overload fault and reset.
module tb_laser_aom_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [1:0]  src_mask_i;
  logic        req0_en_i, req1_en_i;
  logic [11:0] req0_vol_i, req1_vol_i;
  logic [11:0] aom_overload_vol_thre_i;
  logic [31:0] aom_overload_timeout_i;
  logic        fault_clr_i;
  logic        dac_valid_o;
  logic [11:0] dac_data_o;
  logic        dac_ready_i;
  logic [11:0] aom_voltage_o;
  logic        overload_fault_o, busy_o;
  logic [15:0] ovr_cnt_o;
  int          n_tests = 0;
  int          n_fail = 0;
  laser_aom_arbiter #(.SETTLE_CYC(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .src_mask_i(src_mask_i),
    .req0_en_i(req0_en_i), .req1_en_i(req1_en_i),
    .req0_vol_i(req0_vol_i), .req1_vol_i(req1_vol_i),
    .aom_overload_vol_thre_i(aom_overload_vol_thre_i),
    .aom_overload_timeout_i(aom_overload_timeout_i),
    .fault_clr_i(fault_clr_i), .dac_valid_o(dac_valid_o), .dac_data_o(dac_data_o),
    .dac_ready_i(dac_ready_i), .aom_voltage_o(aom_voltage_o),
    .overload_fault_o(overload_fault_o), .busy_o(busy_o), .ovr_cnt_o(ovr_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic pulse(input int src, input logic [11:0] vol);
    if (src == 1) begin req1_en_i = 1'b1; req1_vol_i = vol; end
    else begin req0_en_i = 1'b1; req0_vol_i = vol; end
    step();
    req0_en_i = 1'b0;
    req1_en_i = 1'b0;
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!dac_valid_o && n < 100) begin step(); n++; end
    chk(tag, dac_valid_o, 1);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 100) begin step(); n++; end
    chk(tag, busy_o, 0);
  endtask
  initial begin
    int n;
    rst_n_i = 1'b0; src_mask_i = 2'b11; req0_en_i = 1'b0; req1_en_i = 1'b0;
    req0_vol_i = 12'h0; req1_vol_i = 12'h0; aom_overload_vol_thre_i = 12'hFFF;
    aom_overload_timeout_i = 32'd0; fault_clr_i = 1'b0; dac_ready_i = 1'b1;
    step(); step();
    chk("rst_valid", dac_valid_o, 0);
    chk("rst_data", dac_data_o, 0);
    chk("rst_aom", aom_voltage_o, 0);
    chk("rst_fault", overload_fault_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovr", ovr_cnt_o, 0);
    rst_n_i = 1'b1;
    step();
    pulse(0, 12'h800);
    chk("lat_c1_valid", dac_valid_o, 0);
    step();
    chk("lat_c2_valid", dac_valid_o, 1);
    chk("lat_c2_data", dac_data_o, 12'h800);
    step();
    chk("lat_c3_aom", aom_voltage_o, 12'h800);
    chk("lat_c3_valid", dac_valid_o, 0);
    for (int i = 0; i < 15; i++) step();
    chk("settle_c18_busy", busy_o, 1);
    step();
    chk("settle_c19_busy", busy_o, 0);
    req0_en_i = 1'b1; req0_vol_i = 12'h100;
    req1_en_i = 1'b1; req1_vol_i = 12'h200;
    step();
    req0_en_i = 1'b0; req1_en_i = 1'b0;
    step();
    chk("prio_first", dac_data_o, 12'h200);
    step();
    chk("prio_aom1", aom_voltage_o, 12'h200);
    for (int i = 0; i < 17; i++) step();
    chk("prio_second_valid", dac_valid_o, 1);
    chk("prio_second", dac_data_o, 12'h100);
    chk("prio_ovr", ovr_cnt_o, 0);
    wait_idle("prio_idle");
    src_mask_i = 2'b10;
    pulse(0, 12'h0AB);
    step(); step();
    chk("masked_busy", busy_o, 0);
    chk("masked_ovr", ovr_cnt_o, 0);
    src_mask_i = 2'b11;
    dac_ready_i = 1'b0;
    pulse(0, 12'h011);
    step();
    pulse(0, 12'h022);
    src_mask_i = 2'b10;
    step();
    src_mask_i = 2'b11;
    dac_ready_i = 1'b1;
    step();
    chk("mclr_aom", aom_voltage_o, 12'h011);
    wait_idle("mclr_idle");
    step();
    chk("mclr_dropped", busy_o, 0);
    dac_ready_i = 1'b0;
    pulse(0, 12'h055);
    step();
    for (int k = 1; k <= 3; k++) begin
      pulse(1, 12'(k * 16));
      step();
      chk("stall_data", dac_data_o, 12'h055);
    end
    step(); step();
    chk("stall_valid", dac_valid_o, 1);
    chk("stall_ovr", ovr_cnt_o, 2);
    dac_ready_i = 1'b1;
    step();
    chk("stall_aom", aom_voltage_o, 12'h055);
    wait_valid("stall_wait");
    chk("stall_second", dac_data_o, 12'h030);
    step();
    chk("stall_aom2", aom_voltage_o, 12'h030);
    dac_ready_i = 1'b0;
    wait_idle("stall_idle");
    pulse(0, 12'h444);
    step();
    pulse(1, 12'h555);
    rst_n_i = 1'b0;
    step();
    chk("mid_rst_valid", dac_valid_o, 0);
    chk("mid_rst_data", dac_data_o, 0);
    chk("mid_rst_aom", aom_voltage_o, 0);
    chk("mid_rst_ovr", ovr_cnt_o, 0);
    rst_n_i = 1'b1; dac_ready_i = 1'b1;
    step(); step(); step();
    chk("mid_rst_lost", busy_o, 0);
    aom_overload_vol_thre_i = 12'h700; aom_overload_timeout_i = 32'd100;
    pulse(0, 12'hFFF);
    step(); step();
    chk("ovl_aom", aom_voltage_o, 12'hFFF);
    n = 0;
    while (!overload_fault_o && n < 200) begin step(); n++; end
    chk("ovl_cycles", n, 100);
    chk("ovl_fissue_valid", dac_valid_o, 1);
    chk("ovl_fissue_data", dac_data_o, 0);
    step();
    chk("ovl_hold_aom", aom_voltage_o, 0);
    chk("ovl_hold_busy", busy_o, 1);
    pulse(0, 12'h123);
    step(); step();
    chk("ovl_ignored_valid", dac_valid_o, 0);
    chk("ovl_ignored_fault", overload_fault_o, 1);
    chk("ovl_ignored_ovr", ovr_cnt_o, 0);
    fault_clr_i = 1'b1;
    step();
    fault_clr_i = 1'b0;
    chk("clr_fault", overload_fault_o, 0);
    chk("clr_busy", busy_o, 0);
    pulse(0, 12'h321);
    step();
    chk("clr_reissue", dac_data_o, 12'h321);
    chk("clr_reissue_valid", dac_valid_o, 1);
    wait_idle("clr_idle");
    aom_overload_timeout_i = 32'd0;
    pulse(0, 12'hFFF);
    step(); step();
    wait_idle("to0_idle");
    for (int i = 0; i < 30; i++) step();
    chk("to0_nofault", overload_fault_o, 0);
    dac_ready_i = 1'b0;
    pulse(0, 12'h0AA);
    step();
    chk("fiss_data", dac_data_o, 12'h0AA);
    aom_overload_timeout_i = 32'd5;
    fault_clr_i = 1'b1;
    step();
    fault_clr_i = 1'b0;
    chk("fiss_fault", overload_fault_o, 1);
    step();
    chk("fiss_hold_valid", dac_valid_o, 1);
    chk("fiss_hold_data", dac_data_o, 12'h0AA);
    dac_ready_i = 1'b1;
    step();
    chk("fiss_aom", aom_voltage_o, 12'h0AA);
    chk("fiss_zero_valid", dac_valid_o, 1);
    chk("fiss_zero_data", dac_data_o, 0);
    step();
    chk("fiss_hold_aom", aom_voltage_o, 0);
    chk("fiss_hold_busy", busy_o, 1);
    fault_clr_i = 1'b1;
    step();
    fault_clr_i = 1'b0;
    chk("fiss_clr", busy_o, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
